// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the word-to-bitstream packetizer.
package bitstream_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // 0 or anything wider than the word means "send the whole word".
    function automatic int eff_nbits(input int nbits, input int width);
        return (nbits == 0 || nbits > width) ? width : nbits;
    endfunction

endpackage

// File: rtl/bitstream_packetizer_piso.sv
// Parallel-in serial-out shifter: MSB-first, with a down-counter of bits left.
module piso_shifter #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNTW-1:0]  i_cnt,
    output logic             o_msb,
    output logic             o_last
);
    logic [WIDTH-1:0] r_shreg;
    logic [CNTW-1:0]  r_cnt;

    // Load wins over shift so the next word can replace the final bit in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= i_cnt;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign o_msb  = r_shreg[WIDTH-1];
    assign o_last = (r_cnt == CNTW'(1));
endmodule

// File: rtl/bitstream_packetizer.sv
// Packet word source to framed serial bitstream (valid/ready/sop/eop), MSB first.
module bitstream_packetizer
    import bitstream_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNTW-1:0]  i_nbits,
    output logic             outp,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_sop,
    output logic             o_eop,
    output logic             err
);
    state_t r_state, w_next;
    logic   r_sop, r_eop, r_in_pkt, r_err;
    logic   w_msb, w_last, w_xfer, w_last_xfer;
    logic   w_acc, w_discard, w_sop_err, w_load;
    logic [CNTW-1:0] w_cnt;

    assign o_valid     = (r_state == ST_SHIFT);
    assign w_xfer      = o_valid & o_ready;
    assign w_last_xfer = w_xfer & w_last;
    // Ready during the final bit transfer lets the next word follow without a bubble.
    assign i_ready     = (r_state == ST_IDLE) | w_last_xfer;

    assign w_acc     = i_valid & i_ready;
    assign w_discard = w_acc & ~i_sop & ~r_in_pkt;
    assign w_sop_err = w_acc & i_sop & r_in_pkt;
    assign w_load    = w_acc & ~w_discard;
    assign w_cnt     = i_eop ? CNTW'(eff_nbits(int'(i_nbits), WIDTH)) : CNTW'(WIDTH);

    piso_shifter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_xfer),
        .i_data  (i_data),
        .i_cnt   (w_cnt),
        .o_msb   (w_msb),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last_xfer && !w_load) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_in_pkt <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_discard | w_sop_err;
            if (w_load) begin
                r_sop    <= i_sop;
                r_eop    <= i_eop;
                r_in_pkt <= ~i_eop & (i_sop | r_in_pkt);
            end else if (w_xfer) begin
                r_sop <= 1'b0;
            end
        end
    end

    assign outp  = o_valid & w_msb;
    assign o_sop = o_valid & r_sop;
    assign o_eop = o_valid & r_eop & w_last;
    assign err   = r_err;
endmodule

// File: tb/tb_bitstream_packetizer.sv
// Directed bench for bitstream_packetizer (WIDTH=8).
module tb_bitstream_packetizer;
    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid, i_ready, i_sop, i_eop;
    logic [7:0] i_data;
    logic [3:0] i_nbits;
    logic       outp, o_valid, o_ready, o_sop, o_eop, err;
    int         npass = 0;
    int         ntot  = 0;

    bitstream_packetizer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_sop(i_sop), .i_eop(i_eop),
        .i_data(i_data), .i_nbits(i_nbits),
        .outp(outp), .o_valid(o_valid), .o_ready(o_ready),
        .o_sop(o_sop), .o_eop(o_eop), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // One sop+eop word; optional 1,0,0 o_ready stall pattern.
    task automatic single(input string tag, input logic [7:0] d, input logic [3:0] nb,
                          input int nexp, input bit stall);
        int idx = 0;
        int c   = 0;
        bit rdy;
        i_valid = 1; i_sop = 1; i_eop = 1; i_data = d; i_nbits = nb; o_ready = 1;
        #1 chk({tag, ".acc_rdy"}, i_ready, 1);
        cyc();
        i_valid = 0;
        while (idx < nexp && c < 64) begin
            rdy = stall ? (c % 3 == 0) : 1'b1;
            o_ready = rdy;
            #1;
            chk({tag, ".vld"},  o_valid, 1);
            chk({tag, ".outp"}, outp, d[7-idx]);
            chk({tag, ".sop"},  o_sop, idx == 0);
            chk({tag, ".eop"},  o_eop, idx == nexp - 1);
            chk({tag, ".irdy"}, i_ready, (idx == nexp - 1) && rdy);
            chk({tag, ".err"},  err, 0);
            if (rdy) idx++;
            c++;
            cyc();
        end
        o_ready = 1;
        chk({tag, ".nbits_sent"}, idx, nexp);
        #1 chk({tag, ".idle"}, o_valid, 0);
    endtask

    // Two back-to-back words: w1 (sop) then w2 (eop, optional sop) held valid.
    task automatic pair(input string tag, input logic [7:0] w1, input logic [7:0] w2,
                        input bit s2);
        logic [15:0] pat;
        pat = {w1, w2};
        i_valid = 1; i_sop = 1; i_eop = 0; i_data = w1; i_nbits = 0; o_ready = 1;
        #1 chk({tag, ".acc_rdy"}, i_ready, 1);
        cyc();
        i_data = w2; i_sop = s2; i_eop = 1;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) i_valid = 0;
            #1;
            chk({tag, ".vld"},  o_valid, 1);
            chk({tag, ".outp"}, outp, pat[15-k]);
            chk({tag, ".sop"},  o_sop, (k == 0) || (k == 8 && s2));
            chk({tag, ".eop"},  o_eop, k == 15);
            chk({tag, ".err"},  err, (k == 8) && s2);
            chk({tag, ".irdy"}, i_ready, (k == 7) || (k == 15));
            cyc();
        end
        #1 chk({tag, ".idle"}, o_valid, 0);
    endtask

    initial begin
        reset = 1; i_valid = 0; i_sop = 0; i_eop = 0; i_data = 0; i_nbits = 0; o_ready = 1;
        #12;
        chk("rst.vld",  o_valid, 0);
        chk("rst.outp", outp, 0);
        chk("rst.sop",  o_sop, 0);
        chk("rst.eop",  o_eop, 0);
        chk("rst.err",  err, 0);
        @(posedge clk); #3 reset = 0;
        cyc();
        chk("rst.irdy", i_ready, 1);

        single("a5",    8'hA5, 4'd0,  8, 1'b0);
        single("part3", 8'hE0, 4'd3,  3, 1'b0);
        single("nb12",  8'h81, 4'd12, 8, 1'b0);
        single("bp",    8'hA5, 4'd0,  8, 1'b1);

        // Non-sop word outside a packet is dropped with an error pulse.
        i_valid = 1; i_sop = 0; i_eop = 0; i_data = 8'h55;
        #1 chk("disc.acc_rdy", i_ready, 1);
        cyc();
        i_valid = 0;
        #1 chk("disc.err", err, 1);
        chk("disc.vld", o_valid, 0);
        cyc();
        #1 chk("disc.err_clr", err, 0);
        chk("disc.vld2", o_valid, 0);

        pair("f00f", 8'hF0, 8'h0F, 1'b0);
        pair("sop_err", 8'hC3, 8'h81, 1'b1);

        // Async reset in the middle of an open packet.
        i_valid = 1; i_sop = 1; i_eop = 0; i_data = 8'hA5; i_nbits = 0; o_ready = 1;
        cyc();
        i_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("mid.outp", outp, (k % 2 == 0));
            cyc();
        end
        #1 chk("mid.b4_vld", o_valid, 1);
        chk("mid.b4_outp", outp, 0);
        reset = 1;
        #1 chk("mid.async_vld", o_valid, 0);
        chk("mid.async_sop", o_sop, 0);
        cyc();
        reset = 0;
        cyc();
        single("post_rst", 8'h80, 4'd1, 1, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/bitstream_packetizer.md
Name: bitstream_packetizer

Overview:
- Transmit-side companion to the serial bit detector: converts packets of parallel words into a serial 1-bit stream.
- Output stream is framed with valid/ready/sop/eop exactly as the detector consumes it.
- Sits between a word-oriented packet source and the detector input, or drives a serial link that the detector monitors.
- Bits are sent MSB-first; full throughput is one bit per clock under continuous o_ready.

Parameters:
- WIDTH, 8, bits per input word (2..32).
- CNTW, $clog2(WIDTH+1), derived localparam; width of bit counters and i_nbits. Not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  input word valid
- i_ready  out  1  block accepts the word this cycle
- i_sop  in  1  word is first of packet
- i_eop  in  1  word is last of packet
- i_data  in  WIDTH  word; bit WIDTH-1 is transmitted first
- i_nbits  in  CNTW  valid bits in an eop word, taken from the MSB end; 0 or >WIDTH means WIDTH; ignored when i_eop=0
- outp  out  1  serial data bit
- o_valid  out  1  outp/o_sop/o_eop are valid
- o_ready  in  1  downstream accepts the bit
- o_sop  out  1  first bit of packet
- o_eop  out  1  last bit of packet
- err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset: state IDLE; shift register, counters, and in_pkt cleared; outputs outp=0, o_valid=0, o_sop=0, o_eop=0, err=0; i_ready=1 once reset deasserts.
- Word handshake: accept when i_valid & i_ready.
- Bit handshake: transfer when o_valid & o_ready.
- While o_valid=1 and o_ready=0, outp, o_sop, and o_eop hold stable.
- States:
  - IDLE: o_valid=0, i_ready=1. An accepted word loads the shift register and bit count, then moves to SHIFT.
  - SHIFT: o_valid=1, outp=shreg[WIDTH-1]. Each bit transfer shifts left and decrements the count.
- i_ready in SHIFT is 1 only in the cycle where the last bit of the current word transfers. This combinational path from o_ready gives back-to-back words with no bubble.
- If the last bit transfers and no word is accepted, return to IDLE.
- Latency: word accepted in cycle N, so its first bit has o_valid=1 in cycle N+1.
- o_sop is 1 on the first bit of a word accepted with i_sop=1, and 0 on all other bits.
- o_eop is 1 on the final bit of a word accepted with i_eop=1, i.e. bit number nbits.
- A word with i_sop=1 and i_eop=1 is a single-word packet.
- Packet tracking: in_pkt is set on an accepted sop word and cleared on an accepted eop word.
- Framing errors (each raises err for one cycle, in the cycle after acceptance):
  - Word without i_sop while in_pkt=0: discarded, emits no bits, no state change other than err.
  - Word with i_sop while in_pkt=1: accepted as the start of a new packet. The previous packet is left without an eop; the downstream detector must tolerate this.
- Reset mid-packet: all state is lost immediately (asynchronous). No partial eop is emitted. The next packet must start with sop.
- i_nbits=1 on an eop word: one bit is sent, with o_eop=1; it also carries o_sop=1 if that word has sop.

Decomposition:
- Package bitstream_pkg:
  - state enum {ST_IDLE, ST_SHIFT}
  - function eff_nbits(nbits) returning WIDTH for 0 or out-of-range values
- Sub-module piso_shifter (parallel load, shift-left, down-counter, last_bit flag).
- Top level holds the FSM, sop/eop flag registers, in_pkt, and err.

Test Plan:
- Single word 0xA5, sop=eop=1, nbits=0, o_ready=1:
  - outp=1,0,1,0,0,1,0,1 on cycles N+1..N+8.
  - o_sop only on N+1, o_eop only on N+8.
  - i_ready=1 again at N+8.
- Two-word packet 0xF0 (sop), then 0x0F (eop), i_valid held, o_ready=1:
  - 16 contiguous valid bits 1111000000001111 with no bubble.
  - o_sop on bit 1, o_eop on bit 16.
- Partial eop: word 0xE0, sop=eop=1, nbits=3 -> 3 bits 1,1,1 with o_eop on the third, then o_valid=0.
- Backpressure: 0xA5 with o_ready toggled 1,0,0,1,... -> outp/o_sop/o_eop stable while stalled; the sequence matches the first scenario; i_ready stays 0 until the final bit transfers.
- Framing errors:
  - Word 0x55 with sop=0 after reset -> discarded, err=1 for one cycle, o_valid stays 0.
  - sop word during an open packet -> err=1, new packet's first bit carries o_sop=1.
- Reset asserted at bit 4 of 0xA5 -> o_valid=0 asynchronously; after release, a new sop word 0x80 nbits=1 yields a single bit 1 with o_sop=o_eop=1.
